// File: rtl/imem_pkg.sv
// imem_pkg: shared types and constants for the instruction memory controller.
// Holds the controller state encoding, the fetch fault codes and the RV32 NOP.
package imem_pkg;

    typedef enum logic [1:0] {
        ST_CLEAR = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2,
        ST_LOAD  = 2'd3
    } imem_state_e;

    localparam logic [1:0] FLT_OK       = 2'b00;
    localparam logic [1:0] FLT_MISALIGN = 2'b01;
    localparam logic [1:0] FLT_RANGE    = 2'b10;
    localparam logic [1:0] FLT_PARITY   = 2'b11;

    // ADDI x0,x0,0
    localparam logic [31:0] RV32_NOP = 32'h0000_0013;

endpackage

// File: rtl/imem_array.sv
// imem_array: single-port storage with synchronous write and a synchronous,
// enable-held read register. The read register doubles as the response data
// register, so it only updates on an accepted fetch and otherwise holds.
// The controller never asserts we and re together.
module imem_array #(
    parameter int W     = 32,
    parameter int DEPTH = 1024,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          we,
    input  logic          re,
    input  logic [AW-1:0] addr,
    input  logic [W-1:0]  wdata,
    output logic [W-1:0]  rdata
);

    logic [W-1:0] mem_r [DEPTH];
    logic [W-1:0] rdata_r;

    // Word write on the shared port
    always_ff @(posedge clk) begin
        if (we) begin
            mem_r[addr] <= wdata;
        end
    end

    // Read register: captures the addressed word only when a fetch is accepted
    always_ff @(posedge clk) begin
        if (re) begin
            rdata_r <= mem_r[addr];
        end
    end

    assign rdata = rdata_r;

endmodule

// File: rtl/instr_mem_ctrl.sv
// instr_mem_ctrl: instruction memory with a back-pressured, registered fetch
// port and a handshaked loader port. After reset every word is overwritten
// with NOP_WORD (CLEAR), then fetches are served (RUN). Loader mode (LOAD) is
// entered on load_req, via DRAIN when a response is still pending.
// Optional feature macro: IMEM_PARITY_EN (per-word even parity, fault 11).
module instr_mem_ctrl
    import imem_pkg::*;
#(
    parameter int              XLEN     = 32,
    parameter int              DEPTH    = 1024,
    parameter logic [XLEN-1:0] NOP_WORD = XLEN'(RV32_NOP),
    parameter int              AW       = $clog2(DEPTH)
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            load_req,
    input  logic            load_done,
    input  logic            load_valid,
    input  logic [AW-1:0]   load_addr,
    input  logic [XLEN-1:0] load_data,
    output logic            load_ready,
    input  logic            fetch_valid,
    input  logic [XLEN-1:0] fetch_addr,
    output logic            fetch_ready,
    output logic            rsp_valid,
    output logic [XLEN-1:0] rsp_data,
    output logic [1:0]      rsp_fault,
    input  logic            rsp_ready,
    output logic            busy
);

`ifdef IMEM_PARITY_EN
    localparam int MW = XLEN + 1;
`else
    localparam int MW = XLEN;
`endif

    // Stored word: data, plus an even-parity bit on top when enabled
    function automatic logic [MW-1:0] make_word(input logic [XLEN-1:0] d);
`ifdef IMEM_PARITY_EN
        make_word = {^d, d};
`else
        make_word = d;
`endif
    endfunction

    imem_state_e     state_r;
    imem_state_e     state_nxt_s;
    logic [AW-1:0]   cnt_r;
    logic            rsp_valid_r;
    logic [1:0]      flt_r;
    logic            use_mem_r;
    logic            fetch_ready_s;
    logic            fetch_acc_s;
    logic [1:0]      addr_flt_s;
    logic            mem_we_s;
    logic            mem_re_s;
    logic [AW-1:0]   mem_addr_s;
    logic [MW-1:0]   mem_wdata_s;
    logic [MW-1:0]   mem_rdata_s;
    logic            par_err_s;

    // Address fault classification; misalignment wins over range
    always_comb begin
        addr_flt_s = FLT_OK;
        if (fetch_addr[1:0] != 2'b00) begin
            addr_flt_s = FLT_MISALIGN;
        end else if (|fetch_addr[XLEN-1:AW+2]) begin
            addr_flt_s = FLT_RANGE;
        end else begin
            addr_flt_s = FLT_OK;
        end
    end

    assign fetch_ready_s = (state_r == ST_RUN) && !load_req && (!rsp_valid_r || rsp_ready);
    assign fetch_acc_s   = fetch_valid && fetch_ready_s;

    // Single array port arbitration: CLEAR writes, then loader writes, then fetch reads
    always_comb begin
        mem_we_s    = 1'b0;
        mem_re_s    = 1'b0;
        mem_addr_s  = fetch_addr[AW+1:2];
        mem_wdata_s = make_word(NOP_WORD);
        case (state_r)
            ST_CLEAR: begin
                mem_we_s    = 1'b1;
                mem_addr_s  = cnt_r;
                mem_wdata_s = make_word(NOP_WORD);
            end
            ST_LOAD: begin
                mem_we_s    = load_valid;
                mem_addr_s  = load_addr;
                mem_wdata_s = make_word(load_data);
            end
            ST_RUN: begin
                mem_re_s = fetch_acc_s && (addr_flt_s == FLT_OK);
            end
            default: begin
                mem_we_s = 1'b0;
                mem_re_s = 1'b0;
            end
        endcase
    end

    imem_array #(
        .W     (MW),
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_array (
        .clk   (clk),
        .we    (mem_we_s),
        .re    (mem_re_s),
        .addr  (mem_addr_s),
        .wdata (mem_wdata_s),
        .rdata (mem_rdata_s)
    );

    // Next-state selection
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            ST_CLEAR: begin
                if (cnt_r == AW'(DEPTH - 1)) begin
                    state_nxt_s = ST_RUN;
                end else begin
                    state_nxt_s = ST_CLEAR;
                end
            end
            ST_RUN: begin
                if (load_req) begin
                    state_nxt_s = rsp_valid_r ? ST_DRAIN : ST_LOAD;
                end else begin
                    state_nxt_s = ST_RUN;
                end
            end
            ST_DRAIN: begin
                if (!rsp_valid_r || rsp_ready) begin
                    state_nxt_s = ST_LOAD;
                end else begin
                    state_nxt_s = ST_DRAIN;
                end
            end
            ST_LOAD: begin
                if (load_done) begin
                    state_nxt_s = ST_RUN;
                end else begin
                    state_nxt_s = ST_LOAD;
                end
            end
            default: begin
                state_nxt_s = ST_CLEAR;
            end
        endcase
    end

    // State register
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_r <= ST_CLEAR;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Clear counter: walks every word index while in CLEAR
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt_r <= {AW{1'b0}};
        end else if (state_r == ST_CLEAR) begin
            cnt_r <= cnt_r + AW'(1);
        end else begin
            cnt_r <= {AW{1'b0}};
        end
    end

    // Response control: load on accept, drop on consume, hold otherwise
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rsp_valid_r <= 1'b0;
            flt_r       <= FLT_OK;
            use_mem_r   <= 1'b0;
        end else if (fetch_acc_s) begin
            rsp_valid_r <= 1'b1;
            flt_r       <= addr_flt_s;
            use_mem_r   <= (addr_flt_s == FLT_OK);
        end else if (rsp_ready) begin
            rsp_valid_r <= 1'b0;
        end
    end

`ifdef IMEM_PARITY_EN
    assign par_err_s = use_mem_r && (^mem_rdata_s != 1'b0);
`else
    assign par_err_s = 1'b0;
`endif

    // Faulted or reset responses present NOP_WORD instead of array contents
    assign rsp_data    = (use_mem_r && !par_err_s) ? mem_rdata_s[XLEN-1:0] : NOP_WORD;
    assign rsp_fault   = par_err_s ? FLT_PARITY : flt_r;
    assign rsp_valid   = rsp_valid_r;
    assign fetch_ready = fetch_ready_s;
    assign load_ready  = (state_r == ST_LOAD);
    assign busy        = (state_r == ST_CLEAR) || (state_r == ST_LOAD);

endmodule

// File: tb/tb_instr_mem_ctrl.sv
// tb_instr_mem_ctrl: scoreboard bench for instr_mem_ctrl. A negedge monitor
// keeps a word-array reference model, queues the expected response of every
// accepted fetch and checks each presented response against the queue head.
`timescale 1ns/1ps
module tb_instr_mem_ctrl;

    localparam int          XLEN  = 32;
    localparam int          DEPTH = 1024;
    localparam int          AW    = 10;
    localparam logic [31:0] NOP   = 32'h0000_0013;

    typedef struct packed {
        logic [31:0] data;
        logic [1:0]  flt;
    } exp_t;

    logic            clk = 1'b0;
    logic            reset;
    logic            load_req, load_done, load_valid;
    logic [AW-1:0]   load_addr;
    logic [XLEN-1:0] load_data;
    logic            load_ready;
    logic            fetch_valid;
    logic [XLEN-1:0] fetch_addr;
    logic            fetch_ready;
    logic            rsp_valid;
    logic [XLEN-1:0] rsp_data;
    logic [1:0]      rsp_fault;
    logic            rsp_ready;
    logic            busy;

    int   n_checks;
    int   n_fail;
    exp_t exp_q[$];
    logic [31:0] ref_mem [DEPTH];
    bit          ref_bad [DEPTH];

    instr_mem_ctrl dut (
        .clk         (clk),
        .reset       (reset),
        .load_req    (load_req),
        .load_done   (load_done),
        .load_valid  (load_valid),
        .load_addr   (load_addr),
        .load_data   (load_data),
        .load_ready  (load_ready),
        .fetch_valid (fetch_valid),
        .fetch_addr  (fetch_addr),
        .fetch_ready (fetch_ready),
        .rsp_valid   (rsp_valid),
        .rsp_data    (rsp_data),
        .rsp_fault   (rsp_fault),
        .rsp_ready   (rsp_ready),
        .busy        (busy)
    );

    always #5 clk = ~clk;

    function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endfunction

    // Reference fetch result from the memory rules
    function automatic exp_t model_fetch(input logic [31:0] a);
        exp_t e;
        if (a % 4 != 0) begin
            e.flt = 2'b01; e.data = NOP;
        end else if ((a / 4) >= DEPTH) begin
            e.flt = 2'b10; e.data = NOP;
        end else if (ref_bad[a[AW+1:2]]) begin
            e.flt = 2'b11; e.data = NOP;
        end else begin
            e.flt = 2'b00; e.data = ref_mem[a[AW+1:2]];
        end
        return e;
    endfunction

    // Monitor / scoreboard
    always @(negedge clk) begin
        if (!reset) begin
            exp_q.delete();
            for (int i = 0; i < DEPTH; i++) begin
                ref_mem[i] = NOP;
                ref_bad[i] = 1'b0;
            end
        end else begin
            if (rsp_valid) begin
                if (exp_q.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL rsp_unexpected: rsp_valid=1 data %h with no outstanding fetch", rsp_data);
                end else begin
                    chk("rsp_data", rsp_data, exp_q[0].data);
                    chk("rsp_fault", 32'(rsp_fault), 32'(exp_q[0].flt));
                    if (rsp_ready) begin
                        void'(exp_q.pop_front());
                    end
                end
            end
            if (fetch_valid && fetch_ready) begin
                exp_q.push_back(model_fetch(fetch_addr));
            end
            if (load_valid && load_ready) begin
                ref_mem[load_addr] = load_data;
                ref_bad[load_addr] = 1'b0;
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    task automatic check_reset_vals(input string tag);
        chk({tag, "_rsp_valid"}, 32'(rsp_valid), 32'd0);
        chk({tag, "_rsp_data"}, rsp_data, NOP);
        chk({tag, "_rsp_fault"}, 32'(rsp_fault), 32'd0);
        chk({tag, "_fetch_ready"}, 32'(fetch_ready), 32'd0);
        chk({tag, "_load_ready"}, 32'(load_ready), 32'd0);
        chk({tag, "_busy"}, 32'(busy), 32'd1);
    endtask

    task automatic do_fetch(input logic [31:0] a, input bit rnd_ready, output int waited);
        bit acc;
        acc = 1'b0;
        waited = 0;
        fetch_valid = 1'b1;
        fetch_addr = a;
        for (int k = 0; k < 64 && !acc; k++) begin
            if (rnd_ready) rsp_ready = ($urandom_range(0, 3) != 0);
            #1;
            acc = fetch_ready;
            @(posedge clk);
            #2;
            if (!acc) waited++;
        end
        fetch_valid = 1'b0;
        if (!acc) begin
            n_checks++;
            n_fail++;
            $display("FAIL fetch_timeout: addr %h not accepted within 64 cycles", a);
        end
    endtask

    task automatic idle();
        fetch_valid = 1'b0;
        rsp_ready = 1'b1;
        step();
        step();
    endtask

    task automatic wait_clear(output int cycles);
        cycles = 0;
        while (busy && cycles < DEPTH + 16) begin
            step();
            cycles++;
        end
    endtask

    task automatic loader_session(input int nwr, input bit rnd_ready);
        int k;
        load_req = 1'b1;
        k = 0;
        while (!load_ready && k < 64) begin
            if (rnd_ready) rsp_ready = $urandom_range(0, 1);
            step();
            k++;
        end
        chk("loader_entry", 32'(load_ready), 32'd1);
        rsp_ready = 1'b1;
        for (int i = 0; i < nwr; i++) begin
            load_valid = ($urandom_range(0, 3) != 0);
            load_addr  = AW'($urandom_range(0, 15));
            load_data  = $urandom;
            load_done  = (i == nwr - 1);
            step();
        end
        load_valid = 1'b0;
        load_done  = 1'b0;
        load_req   = 1'b0;
    endtask

    function automatic logic [31:0] rand_addr();
        logic [31:0] a;
        case ($urandom_range(0, 9))
            0, 1, 2, 3: a = $urandom_range(0, 15) * 4;
            4, 5:       a = $urandom_range(0, DEPTH - 1) * 4;
            6:          a = ($urandom_range(0, DEPTH - 1) * 4) | $urandom_range(1, 3);
            7:          a = 32'h0000_1000 + $urandom_range(0, 255) * 4;
            8:          a = $urandom;
            default:    a = 32'h0000_0FFC;
        endcase
        return a;
    endfunction

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int w;
        int cyc;
        n_checks = 0;
        n_fail = 0;
        reset = 1'b0;
        load_req = 1'b0; load_done = 1'b0; load_valid = 1'b0;
        load_addr = '0; load_data = '0;
        fetch_valid = 1'b0; fetch_addr = '0; rsp_ready = 1'b1;
        repeat (3) step();
        check_reset_vals("por");

        // CLEAR occupies exactly DEPTH cycles after release
        reset = 1'b1;
        repeat (DEPTH - 1) step();
        chk("busy_last_clear_cycle", 32'(busy), 32'd1);
        chk("fetch_ready_in_clear", 32'(fetch_ready), 32'd0);
        step();
        chk("busy_after_clear", 32'(busy), 32'd0);
        chk("fetch_ready_first_run", 32'(fetch_ready), 32'd1);

        do_fetch(32'h0, 1'b0, w);
        do_fetch(32'hFFC, 1'b0, w);
        do_fetch(32'h7FC, 1'b0, w);
        idle();

        // Directed loader sequence, then back-to-back fetch of the new words
        chk("idle_before_load", 32'(rsp_valid), 32'd0);
        load_req = 1'b1;
        step();
        chk("run_to_load_1cyc", 32'(load_ready), 32'd1);
        chk("busy_in_load", 32'(busy), 32'd1);
        chk("fetch_ready_in_load", 32'(fetch_ready), 32'd0);
        load_valid = 1'b1; load_addr = AW'(3); load_data = 32'hDEAD_BEEF;
        step();
        load_addr = AW'(4); load_data = 32'h00A0_0613; load_done = 1'b1;
        step();
        load_valid = 1'b0; load_done = 1'b0; load_req = 1'b0;
        chk("load_to_run_1cyc", 32'(load_ready), 32'd0);
        chk("busy_after_load", 32'(busy), 32'd0);
        do_fetch(32'hC, 1'b0, w);
        do_fetch(32'h10, 1'b0, w);
        chk("b2b_no_stall", 32'(w), 32'd0);

        // Address faults
        do_fetch(32'h6, 1'b0, w);
        do_fetch(32'h1000, 1'b0, w);
        do_fetch(32'hFFFF_FFFC, 1'b0, w);
        idle();

        // Randomised loader sessions and fetches
        for (int r = 0; r < 3; r++) begin
            loader_session(8, 1'b0);
            for (int i = 0; i < 40; i++) begin
                do_fetch(rand_addr(), 1'b1, w);
                if ($urandom_range(0, 3) == 0) step();
            end
            idle();
        end

        // Back-pressure, then load_req while a response is pending
        rsp_ready = 1'b0;
        do_fetch(32'hC, 1'b0, w);
        fetch_valid = 1'b1; fetch_addr = 32'h10;
        for (int i = 0; i < 5; i++) begin
            #1;
            chk("stall_fetch_ready", 32'(fetch_ready), 32'd0);
            chk("stall_rsp_valid", 32'(rsp_valid), 32'd1);
            step();
        end
        fetch_valid = 1'b0;
        load_req = 1'b1;
        step();
        chk("drain_no_load_ready", 32'(load_ready), 32'd0);
        chk("drain_rsp_held", 32'(rsp_valid), 32'd1);
        chk("drain_fetch_ready", 32'(fetch_ready), 32'd0);
        step();
        chk("drain_still", 32'(load_ready), 32'd0);
        rsp_ready = 1'b1;
        step();
        chk("drain_to_load", 32'(load_ready), 32'd1);
        chk("drain_rsp_dropped", 32'(rsp_valid), 32'd0);

        // Two writes, then reset in the middle of LOAD
        load_valid = 1'b1; load_addr = AW'(7); load_data = 32'h1111_1111;
        step();
        load_addr = AW'(8); load_data = 32'h2222_2222;
        step();
        load_valid = 1'b0;
        reset = 1'b0;
        load_req = 1'b0;
        #1;
        check_reset_vals("mid_load");
        step();
        step();
        reset = 1'b1;
        wait_clear(cyc);
        chk("reclear_length", 32'(cyc), 32'(DEPTH));
        do_fetch(32'h1C, 1'b0, w);
        do_fetch(32'h20, 1'b0, w);
        do_fetch(32'hC, 1'b0, w);
        idle();

`ifdef IMEM_PARITY_EN
        dut.u_array.mem_r[5][XLEN] = ~dut.u_array.mem_r[5][XLEN];
        ref_bad[5] = 1'b1;
        do_fetch(32'h14, 1'b0, w);
        do_fetch(32'h15, 1'b0, w);
        idle();
`endif

        // Random traffic with back-pressure and occasional loader entries
        for (int i = 0; i < 150; i++) begin
            if ($urandom_range(0, 19) == 0) begin
                loader_session(3, 1'b1);
            end
            do_fetch(rand_addr(), 1'b1, w);
        end
        idle();
        chk("scoreboard_empty", 32'(exp_q.size()), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/instr_mem_ctrl.md
# instr_mem_ctrl

Parametrised instruction memory with a registered, back-pressured fetch port for the core's IF stage and a handshaked loader port for the testbench or boot agent. After reset it clears every word to a NOP, then serves fetches; loader mode is entered and left on request. It replaces the combinational-read, direct-write memory and removes its X-filled and misaligned-address hazards.

## Interface
- XLEN, 32, instruction/data word width in bits
- DEPTH, 1024, number of words; power of two, at least 4
- NOP_WORD, 32'h0000_0013, fill and fault word (ADDI x0,x0,0)
- AW, $clog2(DEPTH), derived word-index width; not for override
---
- clk  in  1  rising-edge clock
- reset  in  1  asynchronous, active-low reset
- load_req  in  1  request loader mode; level
- load_done  in  1  end loader mode; sampled only in LOAD
- load_valid  in  1  loader write strobe
- load_addr  in  AW  loader word index
- load_data  in  XLEN  loader write data
- load_ready  out  1  high only in LOAD
- fetch_valid  in  1  fetch request
- fetch_addr  in  XLEN  byte address
- fetch_ready  out  1  request accepted this cycle
- rsp_valid  out  1  response held in the output register
- rsp_data  out  XLEN  instruction word
- rsp_fault  out  2  00 ok, 01 misaligned, 10 out of range, 11 parity
- rsp_ready  in  1  consumer accepts the response
- busy  out  1  high in CLEAR or LOAD

## Operation
- States: CLEAR, RUN, DRAIN, LOAD.
- CLEAR:
  - an AW-bit counter writes NOP_WORD to word 0..DEPTH-1, one per cycle;
  - after writing word DEPTH-1, go to RUN.
- RUN, fetch side:
  - fetch_ready = !load_req && (!rsp_valid || rsp_ready).
  - On fetch_valid && fetch_ready, the output register loads next cycle with the word at fetch_addr >> 2, plus a fault code.
  - fetch_addr[1:0] != 0 gives fault 01.
  - (fetch_addr >> 2) >= DEPTH gives fault 10; the full XLEN address is compared, with no wrap-around.
  - On any fault, rsp_data = NOP_WORD.
  - The response stays stable until rsp_ready; then rsp_valid drops unless a new fetch was accepted the same cycle.
- RUN, entering loader mode:
  - load_req high and rsp_valid low: go to LOAD.
  - load_req high and rsp_valid high: go to DRAIN. DRAIN goes to LOAD once the pending response is accepted.
- LOAD:
  - load_ready = 1; each cycle with load_valid high writes load_data to word load_addr.
  - fetch_ready = 0.
  - load_done high goes to RUN next cycle; a load_valid in that same cycle is still written.
- Back-to-back write then fetch of the same word returns the new data; the write completes before RUN is re-entered.
- load_req held during CLEAR is honoured after CLEAR ends (CLEAR goes to RUN, which then goes to DRAIN or LOAD).
- reset asserted mid-operation, in any state:
  - returns to CLEAR with the counter at 0;
  - any pending response is discarded;
  - memory contents are rewritten.

## Timing
- Reset values: rsp_valid 0, rsp_data NOP_WORD, rsp_fault 00, fetch_ready 0, load_ready 0, busy 1.
- CLEAR lasts exactly DEPTH cycles after reset deasserts; fetch_ready can first be high in cycle DEPTH.
- Fetch latency is 1 cycle: a request accepted at edge N gives rsp_valid high after edge N.
- Sustained throughput is 1 fetch per cycle while rsp_ready is held high.
- RUN to LOAD takes 1 cycle with no response pending.
- LOAD to RUN takes 1 cycle after load_done.
- Loader writes take effect at the edge where load_valid && load_ready.

## Configuration
- IMEM_PARITY_EN defined:
  - each word stores an extra even-parity bit, computed on CLEAR and loader writes;
  - a mismatch on a fetch gives fault 11 with rsp_data = NOP_WORD.
  - Faults 01 and 10 take precedence over 11.
- IMEM_PARITY_EN undefined: the array is XLEN wide and fault 11 is never produced.

## Structure
- Package imem_pkg holds:
  - the state enum (CLEAR, RUN, DRAIN, LOAD);
  - the fault-code localparams (FLT_OK, FLT_MISALIGN, FLT_RANGE, FLT_PARITY);
  - the RV32 NOP constant.
- One sub-module, imem_array: a single-port synchronous-write, synchronous-read storage array.
  - Width is XLEN, or XLEN+1 with IMEM_PARITY_EN.
  - Write priority: CLEAR, then loader; fetch reads are blocked during writes by the state machine.

## Test plan
- Reset, then DEPTH cycles: busy falls at cycle DEPTH; fetch 0x0, 0xFFC and 0x7FC each return 0x00000013, fault 00.
- Loader sequence:
  - stimulus: load_req; write word 3 = 0xDEADBEEF and word 4 = 0x00A00613; load_done;
  - response: fetch 0xC returns 0xDEADBEEF; fetch 0x10 the next cycle returns 0x00A00613 back-to-back.
- Fetch 0x6 gives fault 01, data NOP. Fetch 0x1000 (DEPTH=1024) gives fault 10, data NOP.
- Back-pressure and DRAIN:
  - stimulus: rsp_ready held 0 for 5 cycles; assert load_req while a response is pending;
  - response: the response stays stable and fetch_ready stays 0; the block enters DRAIN; LOAD is reached the cycle after rsp_ready rises.
- reset asserted in mid-LOAD after 2 writes: outputs return to reset values immediately; after the new CLEAR, the previously written words read 0x00000013.
- With IMEM_PARITY_EN: force a flipped parity bit in word 5; fetch 0x14 gives fault 11, data NOP.
